// File: rtl/game_sequencer.sv
// Round/match controller for Frogger: sequences play, death, scoring, game over and win,
// and owns the BCD life timer, lives and homes counters. Define GAME_PAUSE_EN to honour the pause input.
module game_sequencer #(
  parameter int ROUND_SECONDS  = 60,
  parameter int FRAMES_PER_SEC = 60,
  parameter int START_LIVES    = 3,
  parameter int HOMES_TO_WIN   = 3,
  parameter int DEATH_FRAMES   = 30
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       frog_hit,
  input  logic       frog_home,
  input  logic       pause,
  output logic       respawn,
  output logic       playing,
  output logic       dying,
  output logic       game_over,
  output logic       game_won,
  output logic [3:0] tens_digit,
  output logic [3:0] ones_digit,
  output logic [1:0] lives,
  output logic [2:0] homes
);

  typedef enum logic [2:0] {IDLE, PLAY, DYING, SCORED, OVER, WON} state_t;

  // Status flags in the order {playing, dying, game_over, game_won}.
  localparam logic [3:0] F_NONE  = 4'b0000;
  localparam logic [3:0] F_PLAY  = 4'b1000;
  localparam logic [3:0] F_DYING = 4'b0100;
  localparam logic [3:0] F_OVER  = 4'b0010;
  localparam logic [3:0] F_WON   = 4'b0001;

  localparam logic [3:0] TENS_INIT  = 4'(ROUND_SECONDS / 10);
  localparam logic [3:0] ONES_INIT  = 4'(ROUND_SECONDS % 10);
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam logic [2:0] HOMES_WIN  = 3'(HOMES_TO_WIN);
  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_SEC - 1);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);

  state_t     state;
  logic [3:0] flags;
  logic [7:0] frame_cnt;
  logic [7:0] death_cnt;
  logic       timer_zero;
  logic       paused;
  logic [2:0] homes_inc;

  assign {playing, dying, game_over, game_won} = flags;
  assign timer_zero = (tens_digit == 4'd0) && (ones_digit == 4'd0);
  assign homes_inc  = homes + 3'd1;

`ifdef GAME_PAUSE_EN
  assign paused = pause && (state == PLAY);
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign paused       = 1'b0;
`endif

  // NOTE: every register here is state, so all updates use <= to read pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      flags      <= F_NONE;
      respawn    <= 1'b0;
      tens_digit <= TENS_INIT;
      ones_digit <= ONES_INIT;
      lives      <= LIVES_INIT;
      homes      <= 3'd0;
      frame_cnt  <= 8'd0;
      death_cnt  <= 8'd0;
    end else begin
      respawn <= 1'b0;
      case (state)
        IDLE, OVER, WON: begin
          if (start) begin
            state      <= PLAY;
            flags      <= F_PLAY;
            respawn    <= 1'b1;
            tens_digit <= TENS_INIT;
            ones_digit <= ONES_INIT;
            frame_cnt  <= 8'd0;
            lives      <= LIVES_INIT;
            homes      <= 3'd0;
          end
        end

        PLAY: begin
          // A hit outranks a timeout, which outranks reaching home; both death causes act alike.
          if ((frog_hit && !paused) || timer_zero) begin
            state     <= DYING;
            flags     <= F_DYING;
            lives     <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
            death_cnt <= 8'd0;
          end else if (frog_home && !paused) begin
            state <= SCORED;
            flags <= F_NONE;
          end else if (frame_tick && !paused) begin
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= 8'd0;
              // Timer is nonzero here, so a borrow from tens cannot underflow.
              if (ones_digit == 4'd0) begin
                ones_digit <= 4'd9;
                tens_digit <= tens_digit - 4'd1;
              end else begin
                ones_digit <= ones_digit - 4'd1;
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end

        DYING: begin
          if (frame_tick) begin
            if (death_cnt == DEATH_LAST) begin
              if (lives == 2'd0) begin
                state <= OVER;
                flags <= F_OVER;
              end else begin
                state      <= PLAY;
                flags      <= F_PLAY;
                respawn    <= 1'b1;
                tens_digit <= TENS_INIT;
                ones_digit <= ONES_INIT;
                frame_cnt  <= 8'd0;
              end
            end else begin
              death_cnt <= death_cnt + 8'd1;
            end
          end
        end

        SCORED: begin
          homes <= homes_inc;
          if (homes_inc == HOMES_WIN) begin
            state <= WON;
            flags <= F_WON;
          end else begin
            state      <= PLAY;
            flags      <= F_PLAY;
            respawn    <= 1'b1;
            tens_digit <= TENS_INIT;
            ones_digit <= ONES_INIT;
            frame_cnt  <= 8'd0;
          end
        end

        default: begin
          state <= IDLE;
          flags <= F_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer with default parameters;
// expected values are hand-computed from the round/death/score rules.
module tb_game_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_tick, start, frog_hit, frog_home, pause;
  logic       respawn, playing, dying, game_over, game_won;
  logic [3:0] tens_digit, ones_digit;
  logic [1:0] lives;
  logic [2:0] homes;

  int n_checks = 0;
  int n_fail   = 0;

  game_sequencer dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .start      (start),
    .frog_hit   (frog_hit),
    .frog_home  (frog_home),
    .pause      (pause),
    .respawn    (respawn),
    .playing    (playing),
    .dying      (dying),
    .game_over  (game_over),
    .game_won   (game_won),
    .tens_digit (tens_digit),
    .ones_digit (ones_digit),
    .lives      (lives),
    .homes      (homes)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then return 1 time unit after the sampling edge.
  task automatic cyc(input logic t, input logic h, input logic hm, input logic s);
    frame_tick = t;
    frog_hit   = h;
    frog_home  = hm;
    start      = s;
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
    frog_hit   = 1'b0;
    frog_home  = 1'b0;
    start      = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [7:0] timer();
    return {tens_digit, ones_digit};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b0;
    {frame_tick, start, frog_hit, frog_home, pause} = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_flags", {playing, dying, game_over, game_won, respawn}, 5'b00000);
    check("rst_timer", timer(), 8'h60);
    check("rst_lives", lives, 2'd3);
    check("rst_homes", homes, 3'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Start: PLAY with a single respawn pulse.
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("idle_ignores_home", {playing, homes}, 4'b0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("start_playing", playing, 1'b1);
    check("start_respawn", respawn, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("respawn_once", respawn, 1'b0);
    check("start_ignored_in_play", timer(), 8'h60);

    // One second is FRAMES_PER_SEC ticks.
    ticks(59);
    check("timer_59_ticks", timer(), 8'h60);
    ticks(1);
    check("timer_60_ticks", timer(), 8'h59);
    ticks(540);
    check("timer_tens_borrow", timer(), 8'h50);

    // Timeout: run the remaining 50 s to 00, then frog_home loses to timeout.
    ticks(3000);
    check("timer_zero", timer(), 8'h00);
    check("zero_still_playing", playing, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("timeout_dying", {playing, dying}, 2'b01);
    check("timeout_lives", lives, 2'd2);
    check("timeout_homes", homes, 3'd0);
    check("timeout_frozen", timer(), 8'h00);

    // Inputs other than frame_tick are ignored while dying.
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("dying_ignores", {dying, lives, homes}, 6'b1_10_000);
    ticks(29);
    check("dying_29", {playing, dying}, 2'b01);
    ticks(1);
    check("respawn_after_death", {playing, dying, respawn}, 3'b101);
    check("reload_after_death", timer(), 8'h60);

    // Simultaneous hit and home: hit wins.
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("hit_beats_home", {dying, lives, homes}, 6'b1_01_000);
    ticks(30);
    check("second_respawn", {playing, respawn, lives}, 4'b1_1_01);

    // Third death ends the game.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("third_death_lives", {dying, lives}, 3'b1_00);
    ticks(30);
    check("game_over", {playing, dying, game_over, game_won, respawn}, 5'b00100);
    check("over_timer_held", timer(), 8'h60);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("over_sticky", {game_over, lives}, 3'b1_00);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("restart_from_over", {playing, game_over, respawn, lives, homes}, 8'b1_0_1_11_000);

    // Win: three homes, reload after the first two.
    ticks(65);
    check("win_timer_pre1", timer(), 8'h59);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("scored_state", {playing, homes}, 4'b0_000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("home1", {playing, respawn, homes}, 5'b1_1_001);
    check("home1_reload", timer(), 8'h60);
    ticks(65);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("home2", {playing, respawn, homes}, 5'b1_1_010);
    check("home2_reload", timer(), 8'h60);
    ticks(65);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("home3_won", {playing, game_won, respawn, homes}, 6'b0_1_0_011);
    check("won_timer_held", timer(), 8'h59);
    check("won_lives_held", lives, 2'd3);

    // Reset while dying with one life left.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("restart_from_won", {playing, game_won, homes}, 5'b1_0_000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(30);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("pre_reset_dying", {dying, lives}, 3'b1_01);
    Reset_n = 1'b0;
    #1;
    check("async_reset_flags", {playing, dying, game_over, game_won}, 4'b0000);
    check("async_reset_lives", lives, 2'd3);
    check("async_reset_timer", timer(), 8'h60);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

`ifdef GAME_PAUSE_EN
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    pause = 1'b1;
    ticks(120);
    check("pause_timer", timer(), 8'h60);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("pause_ignores_events", {playing, dying, homes}, 5'b1_0_000);
    pause = 1'b0;
    ticks(60);
    check("unpause_timer", timer(), 8'h59);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
